// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module      : hazard_ctrl_if
// Description : Bundle of D-stage register-usage info, branch/memory status
//               and the stall/flush/forward controls exchanged between the
//               pipelined datapath (master) and hazard_ctrl (slave).
// Ports       : id_* (D-stage instruction info), ex_branch_taken, mem_busy
//               -> controller; stall_f/stall_d, flush_d/flush_e, fwd_a/fwd_b,
//               mem_timeout, stall_count -> datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_regwrite;
    logic              id_memread;
    logic              ex_branch_taken;
    logic              mem_busy;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              mem_timeout;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, ex_branch_taken, mem_busy,
        input  stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b,
               mem_timeout, stall_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_regwrite, id_memread, ex_branch_taken, mem_busy,
        output stall_f, stall_d, flush_d, flush_e, fwd_a, fwd_b,
               mem_timeout, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module      : hazard_ctrl
// Description : Hazard control for the 5-stage F/D/E/M/W pipeline. Shadows
//               the register usage of E, M and W, and produces stall, flush
//               and operand-forwarding selects. Also watches the data-memory
//               busy handshake and flags a stuck memory.
// Ports       : clk, rst (async, active high), hz (hazard_ctrl_if.slave).
// Build macro : HAZARD_FWD_EN - when defined, E operands are forwarded from
//               M/W; when undefined, fwd_a/fwd_b are 00 and any used D source
//               that matches a live E or M producer stalls until the producer
//               reaches W.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 256
) (
    input wire           clk,
    input wire           rst,
    hazard_ctrl_if.slave hz
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_used;
        logic              rs2_used;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } e_ent_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic              memread;
    } mw_ent_t;

    localparam int               BW        = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0]    BUSY_LAST = BW'(TIMEOUT - 1);
    localparam logic [BW-1:0]    BUSY_SAT  = BW'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    e_ent_t           r_e, w_e_nxt;
    mw_ent_t          r_m, r_w, w_m_nxt, w_w_nxt;
    logic [BW-1:0]    r_busy_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_e_live, w_m_live, w_w_live;
    logic w_hit_e, w_hit_m, w_load_use, w_data_stall, w_branch;
    logic w_stall_f, w_stall_d, w_flush_d, w_flush_e;
    logic [1:0] w_fwd_a_calc, w_fwd_b_calc;

    // True when a valid D instruction actually reads register rd.
    function automatic logic reads_reg(
        input logic              valid,
        input logic              u1,
        input logic [REG_AW-1:0] rs1,
        input logic              u2,
        input logic [REG_AW-1:0] rs2,
        input logic [REG_AW-1:0] rd
    );
        return valid && ((u1 && (rs1 == rd)) || (u2 && (rs2 == rd)));
    endfunction

    // M wins over W; loads in M have no data yet, so they are never a source.
    function automatic logic [1:0] fwd_sel(
        input logic              used,
        input logic [REG_AW-1:0] rs,
        input logic              m_ok,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_ok,
        input logic [REG_AW-1:0] w_rd
    );
        if (!used || (rs == '0))   return 2'b00;
        if (m_ok && (m_rd == rs))  return 2'b10;
        if (w_ok && (w_rd == rs))  return 2'b01;
        return 2'b00;
    endfunction

    assign w_e_live = r_e.valid && r_e.regwrite && (r_e.rd != '0);
    assign w_m_live = r_m.valid && r_m.regwrite && (r_m.rd != '0);
    assign w_w_live = r_w.valid && r_w.regwrite && (r_w.rd != '0);

    assign w_hit_e = w_e_live && reads_reg(hz.id_valid, hz.id_rs1_used, hz.id_rs1,
                                           hz.id_rs2_used, hz.id_rs2, r_e.rd);
    assign w_hit_m = w_m_live && reads_reg(hz.id_valid, hz.id_rs1_used, hz.id_rs1,
                                           hz.id_rs2_used, hz.id_rs2, r_m.rd);
    assign w_load_use = w_hit_e && r_e.memread;
    assign w_branch   = r_e.valid && hz.ex_branch_taken;

    assign w_fwd_a_calc = fwd_sel(r_e.rs1_used, r_e.rs1, w_m_live && !r_m.memread,
                                  r_m.rd, w_w_live, r_w.rd);
    assign w_fwd_b_calc = fwd_sel(r_e.rs2_used, r_e.rs2, w_m_live && !r_m.memread,
                                  r_m.rd, w_w_live, r_w.rd);

`ifdef HAZARD_FWD_EN
    logic w_unused;
    assign w_unused     = r_w.memread ^ w_hit_m;
    assign w_data_stall = w_load_use;
    assign hz.fwd_a     = w_fwd_a_calc;
    assign hz.fwd_b     = w_fwd_b_calc;
`else
    // Without bypass paths the consumer waits in D until the producer is in W,
    // where the write-before-read register file hands it the fresh value.
    logic w_unused;
    assign w_unused     = ^{w_fwd_a_calc, w_fwd_b_calc, r_w.memread, w_load_use};
    assign w_data_stall = w_hit_e || w_hit_m;
    assign hz.fwd_a     = 2'b00;
    assign hz.fwd_b     = 2'b00;
`endif

    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        w_e_nxt   = '0;
        if (hz.id_valid) begin
            w_e_nxt = '{valid: 1'b1, rs1: hz.id_rs1, rs2: hz.id_rs2,
                        rs1_used: hz.id_rs1_used, rs2_used: hz.id_rs2_used,
                        rd: hz.id_rd, regwrite: hz.id_regwrite,
                        memread: hz.id_memread};
        end
        w_m_nxt = '{valid: r_e.valid, rd: r_e.rd, regwrite: r_e.regwrite,
                    memread: r_e.memread};
        w_w_nxt = r_m;

        if (hz.mem_busy) begin
            // Freeze: a pending branch waits; E and M hold, W drains.
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_e_nxt   = r_e;
            w_m_nxt   = r_m;
            w_w_nxt   = '0;
        end else if (w_branch) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
            w_e_nxt   = '0;
        end else if (w_data_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
            w_e_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e         <= '0;
            r_m         <= '0;
            r_w         <= '0;
            r_busy_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_e <= w_e_nxt;
            r_m <= w_m_nxt;
            r_w <= w_w_nxt;

            if (!hz.mem_busy) begin
                r_busy_cnt <= '0;
            end else if (r_busy_cnt != BUSY_SAT) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end

            // Sets on the edge that completes the TIMEOUT-th busy cycle.
            if (hz.mem_busy && (r_busy_cnt >= BUSY_LAST)) begin
                r_timeout <= 1'b1;
            end

            if (w_stall_d && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign hz.stall_f     = w_stall_f;
    assign hz.stall_d     = w_stall_d;
    assign hz.flush_d     = w_flush_d;
    assign hz.flush_e     = w_flush_e;
    assign hz.mem_timeout = r_timeout;
    assign hz.stall_count = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed table-driven bench for hazard_ctrl. Each table row
//               is one cycle: the D-stage instruction presented plus the
//               stall/flush/forward outputs expected in that cycle. Hand
//               sequences cover memory timeout and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ins_t;

    typedef struct {
        ins_t       d;
        logic       br;
        logic       busy;
        logic [3:0] ctl;   // {stall_f, stall_d, flush_d, flush_e}
        logic [1:0] fa;
        logic [1:0] fb;
        int         cnt;   // expected stall_count, -1 = not checked
    } vec_t;

    localparam logic [3:0] C_NONE   = 4'b0000;
    localparam logic [3:0] C_STALL  = 4'b1101;
    localparam logic [3:0] C_FREEZE = 4'b1100;
    localparam logic [3:0] C_FLUSH  = 4'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   exp_cnt = 0;
    vec_t vq[$];

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.REG_AW(5), .CNT_W(32), .TIMEOUT(256)) u_dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    function automatic ins_t mk(bit v, int rs1, bit u1, int rs2, bit u2,
                                int rd, bit rw, bit mr);
        ins_t t;
        t.valid = v;   t.rs1 = 5'(rs1); t.u1 = u1;
        t.rs2 = 5'(rs2); t.u2 = u2;     t.rd = 5'(rd);
        t.rw = rw;     t.mr = mr;
        return t;
    endfunction

    task automatic p(ins_t d, bit br, bit busy, logic [3:0] ctl,
                     logic [1:0] fa, logic [1:0] fb, int cnt);
        vec_t v;
        v.d = d; v.br = br; v.busy = busy; v.ctl = ctl;
        v.fa = fa; v.fb = fb; v.cnt = cnt;
        vq.push_back(v);
    endtask

    task automatic drive(ins_t d, bit br, bit busy);
        hz.id_valid        = d.valid;
        hz.id_rs1          = d.rs1;
        hz.id_rs1_used     = d.u1;
        hz.id_rs2          = d.rs2;
        hz.id_rs2_used     = d.u2;
        hz.id_rd           = d.rd;
        hz.id_regwrite     = d.rw;
        hz.id_memread      = d.mr;
        hz.ex_branch_taken = br;
        hz.mem_busy        = busy;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] ctl_now();
        return {hz.stall_f, hz.stall_d, hz.flush_d, hz.flush_e};
    endfunction

    task automatic chk_idle(string nm);
        chk({nm, " ctl"}, 32'(ctl_now()), 32'(C_NONE));
        chk({nm, " fwd"}, 32'({hz.fwd_a, hz.fwd_b}), 32'd0);
    endtask

    initial begin
        ins_t NOP, ADDI5, ADD6, ADDI0, ADD9, LW7, ADD8, BR1, ADDI10, ADD12;
        ins_t BR2, ADDI13, ADDI14, ADD15;
        int   base;

        NOP    = '0;
        ADDI5  = mk(1, 1, 1, 0, 0, 5, 1, 0);
        ADD6   = mk(1, 5, 1, 5, 1, 6, 1, 0);
        ADDI0  = mk(1, 0, 1, 0, 0, 0, 1, 0);
        ADD9   = mk(1, 0, 1, 0, 1, 9, 1, 0);
        LW7    = mk(1, 2, 1, 0, 0, 7, 1, 1);
        ADD8   = mk(1, 7, 1, 1, 1, 8, 1, 0);
        BR1    = mk(1, 3, 1, 4, 1, 0, 0, 0);
        ADDI10 = mk(1, 1, 1, 0, 0, 10, 1, 0);
        ADD12  = mk(1, 10, 1, 10, 1, 12, 1, 0);
        BR2    = mk(1, 1, 1, 0, 0, 0, 0, 0);
        ADDI13 = mk(1, 0, 0, 0, 0, 13, 1, 0);
        ADDI14 = mk(1, 1, 1, 0, 0, 14, 1, 0);
        ADD15  = mk(1, 14, 1, 1, 1, 15, 1, 0);

`ifdef HAZARD_FWD_EN
        // M->E forward, back to back.
        p(ADDI5, 0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(ADD6,  0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE, 2'b10, 2'b10, -1);
        p(NOP,   0, 0, C_NONE, 2'b00, 2'b00, -1);
        // x0 never forwards or stalls.
        p(ADDI0, 0, 0, C_NONE, 2'b00, 2'b00, 0);
        p(ADD9,  0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE, 2'b00, 2'b00, -1);
        // Load-use: one stall, then W->E forward.
        p(LW7,   0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADD8,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD8,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE,  2'b01, 2'b00, 1);
        // Taken branch flushes the younger addi x10.
        p(BR1,    0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADDI10, 1, 0, C_FLUSH, 2'b00, 2'b00, -1);
        p(ADD12,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,  2'b00, 2'b00, -1);
        // Branch held by a 3-cycle freeze.
        p(BR2,    0, 0, C_NONE,   2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 0, C_FLUSH,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,   2'b00, 2'b00, -1);
        // Double producer of x14: M wins over W.
        p(ADDI14, 0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(ADDI14, 0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(ADD15,  0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE, 2'b10, 2'b00, -1);
`else
        // Dependent add waits until addi reaches W.
        p(ADDI5, 0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADD6,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD6,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD6,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE,  2'b00, 2'b00, 2);
        // x0 never stalls.
        p(ADDI0, 0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(ADD9,  0, 0, C_NONE, 2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE, 2'b00, 2'b00, -1);
        // Load-use also waits for W.
        p(LW7,   0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADD8,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD8,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD8,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,   0, 0, C_NONE,  2'b00, 2'b00, 4);
        // Taken branch flushes addi x10; add x12 must not stall on it.
        p(BR1,    0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADDI10, 1, 0, C_FLUSH, 2'b00, 2'b00, -1);
        p(ADD12,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,  2'b00, 2'b00, -1);
        // Branch held by a 3-cycle freeze.
        p(BR2,    0, 0, C_NONE,   2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 1, C_FREEZE, 2'b00, 2'b00, -1);
        p(ADDI13, 1, 0, C_FLUSH,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,   2'b00, 2'b00, -1);
        // x14 producers in E then M both stall add x15.
        p(ADDI14, 0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADDI14, 0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(ADD15,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD15,  0, 0, C_STALL, 2'b00, 2'b00, -1);
        p(ADD15,  0, 0, C_NONE,  2'b00, 2'b00, -1);
        p(NOP,    0, 0, C_NONE,  2'b00, 2'b00, -1);
`endif

        // Reset state.
        drive(NOP, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset timeout", 32'(hz.mem_timeout), 32'd0);
        chk("reset stall_count", hz.stall_count, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].d, vq[i].br, vq[i].busy);
            @(negedge clk);
            chk($sformatf("v%0d ctl", i), 32'(ctl_now()), 32'(vq[i].ctl));
            chk($sformatf("v%0d fwd_a", i), 32'(hz.fwd_a), 32'(vq[i].fa));
            chk($sformatf("v%0d fwd_b", i), 32'(hz.fwd_b), 32'(vq[i].fb));
            if (vq[i].cnt >= 0)
                chk($sformatf("v%0d stall_count", i), hz.stall_count, 32'(vq[i].cnt));
            exp_cnt += int'(vq[i].ctl[2]);
            @(posedge clk);
            #1;
        end
        chk("table stall_count", hz.stall_count, 32'(exp_cnt));

        // Busy run interrupted once must not time out; an unbroken run does.
        base = exp_cnt;
        drive(NOP, 0, 1);
        @(negedge clk);
        chk("busy freeze ctl", 32'(ctl_now()), 32'(C_FREEZE));
        repeat (200) @(posedge clk);
        #1;
        hz.mem_busy = 1'b0;
        @(posedge clk);
        #1;
        hz.mem_busy = 1'b1;
        repeat (255) @(posedge clk);
        #1;
        chk("timeout after 255", 32'(hz.mem_timeout), 32'd0);
        @(posedge clk);
        #1;
        chk("timeout after 256", 32'(hz.mem_timeout), 32'd1);
        hz.mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("timeout sticky", 32'(hz.mem_timeout), 32'd1);
        chk_idle("post busy");
        chk("busy stall_count", hz.stall_count, 32'(base + 200 + 256));

        // Asynchronous reset in the middle of a freeze with E occupied.
        @(posedge clk);
        #1;
        drive(ADDI5, 0, 0);
        @(posedge clk);
        #1;
        drive(ADD6, 0, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst timeout", 32'(hz.mem_timeout), 32'd0);
        chk("async rst stall_count", hz.stall_count, 32'd0);
        hz.mem_busy = 1'b0;
        #1;
        chk_idle("in reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_idle("after reset D");
        @(posedge clk);
        #1;
        drive(NOP, 0, 0);
        @(negedge clk);
        chk_idle("after reset E");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
